// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO widths and data type for the FIFO and its stream reader
package fifo_pkg;
   localparam int FIFO_DATA_WIDTH = 8;
   localparam int FIFO_CNT_WIDTH = 16;
   typedef logic [FIFO_DATA_WIDTH-1:0] data_t;
endpackage

// File: rtl/fifo_skid_buf.sv
// fifo_skid_buf: 2-entry circular buffer absorbing FIFO read latency
module fifo_skid_buf
   import fifo_pkg::*;
#(
   parameter int W = FIFO_DATA_WIDTH
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [1:0]   occ,
   output logic [W-1:0] head
);
   logic [W-1:0] mem_q [2];
   logic [W-1:0] mem_d [2];
   logic         wr_q, wr_d, rd_q, rd_d;
   logic [1:0]   occ_q, occ_d;

   always_comb begin
      mem_d = mem_q;
      if (push) mem_d[wr_q] = push_data;
      wr_d  = wr_q ^ push;
      rd_d  = rd_q ^ pop;
      occ_d = occ_q + {1'b0, push} - {1'b0, pop};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q <= '{default: '0};
         wr_q  <= 1'b0;
         rd_q  <= 1'b0;
         occ_q <= 2'd0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         occ_q <= occ_d;
      end
   end

   assign occ  = occ_q;
   assign head = mem_q[rd_q];
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pops the FIFO and re-presents words as a framed valid/ready stream
module fifo_stream_reader
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int PKT_LEN    = 4,
   parameter int CNT_WIDTH  = FIFO_CNT_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  fifo_empty,
   output logic                  fifo_rd,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic [CNT_WIDTH-1:0]  beat_count,
   output logic                  busy
);
   localparam int IW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(PKT_LEN - 1);

   logic                 inflight_q, inflight_d;
   logic [IW-1:0]        pkt_idx_q, pkt_idx_d;
   logic [CNT_WIDTH-1:0] beat_q, beat_d;
   logic [1:0]           occ;
   logic                 pop;

   fifo_skid_buf #(.W(DATA_WIDTH)) u_buf (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight_q),
      .push_data (fifo_data),
      .pop       (pop),
      .occ       (occ),
      .head      (m_data)
   );

   // Issue only if the buffer can hold everything already owed plus this word
   always_comb begin
      m_valid    = occ != 2'd0;
      pop        = m_valid & m_ready;
      fifo_rd    = !rst & en & !fifo_empty & (occ + {1'b0, inflight_q} <= 2'd1 + {1'b0, pop});
      m_last     = m_valid & (pkt_idx_q == LAST_IDX);
      busy       = m_valid | inflight_q;
      inflight_d = fifo_rd;
      pkt_idx_d  = !pop ? pkt_idx_q : (pkt_idx_q == LAST_IDX) ? '0 : pkt_idx_q + IW'(1);
      beat_d     = pop ? beat_q + CNT_WIDTH'(1) : beat_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight_q <= 1'b0;
         pkt_idx_q  <= '0;
         beat_q     <= '0;
      end else begin
         inflight_q <= inflight_d;
         pkt_idx_q  <= pkt_idx_d;
         beat_q     <= beat_d;
      end
   end

   assign beat_count = beat_q;
endmodule
